// File: rtl/bist_controller.sv
`default_nettype none
// ============================================================================
// Module   : bist_controller
// Purpose  : Scan-based logic BIST sequencer. Runs NUM_PATTERNS shift/capture
//            patterns over a CHAIN_LEN-flop scan chain, unloads the final
//            response, compacts every shifted-out bit into an 8-bit MISR
//            (polynomial 0x1D) and compares the result with GOLDEN_SIG.
// Ports    : clk        - single clock, rising edge
//            rst_n      - synchronous active-low reset
//            start      - request a run (sampled only when idle)
//            scan_out   - serial response from the chain under test
//            abort      - (BIST_ABORT_EN only) abandon the current run
//            scan_en    - 1 = chain shifts, 0 = capture / idle
//            busy       - high whenever not idle
//            done       - one-cycle pulse at the end of a run
//            pass       - final signature matched GOLDEN_SIG
//            signature  - MISR contents
// Config   : define BIST_ABORT_EN to add the abort input.
// Revision : 1.0 - initial release
// ============================================================================
module bist_controller #(
  parameter int         CHAIN_LEN    = 8,
  parameter int         NUM_PATTERNS = 4,
  parameter logic [7:0] GOLDEN_SIG   = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       scan_out,
`ifdef BIST_ABORT_EN
  input  logic       abort,
`endif
  output logic       scan_en,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] signature
);

  localparam int SW = $clog2(CHAIN_LEN + 1);
  localparam int PW = $clog2(NUM_PATTERNS + 1);
  localparam logic [SW-1:0] C_SHIFT_LAST = SW'(CHAIN_LEN - 1);
  localparam logic [PW-1:0] C_PAT_TOTAL  = PW'(NUM_PATTERNS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SHIFT   = 3'd1,
    S_CAPTURE = 3'd2,
    S_UNLOAD  = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   shift_cnt_q, shift_cnt_d;
  logic [PW-1:0]   pat_cnt_q, pat_cnt_d;
  logic [7:0]      sig_q, sig_d;
  logic            pass_q, pass_d;
  logic            scan_en_q, scan_en_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [7:0]      misr_next;
  logic [PW-1:0]   pat_cnt_inc;
  logic            abort_hit;

  // One MISR step: shift left, fold the feedback tap, inject the response bit.
  assign misr_next   = {sig_q[6:0], 1'b0} ^ (sig_q[7] ? 8'h1D : 8'h00)
                       ^ {7'b0, scan_out};
  assign pat_cnt_inc = pat_cnt_q + PW'(1);

`ifdef BIST_ABORT_EN
  assign abort_hit = abort && ((state_q == S_SHIFT) || (state_q == S_CAPTURE) ||
                               (state_q == S_UNLOAD));
`else
  assign abort_hit = 1'b0;
`endif

  // Outputs are registered, so each branch sets the output values that belong
  // to the state being entered, not the state being left.
  always_comb begin
    state_d     = state_q;
    shift_cnt_d = shift_cnt_q;
    pat_cnt_d   = pat_cnt_q;
    sig_d       = sig_q;
    pass_d      = pass_q;
    scan_en_d   = 1'b0;
    busy_d      = 1'b1;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          state_d     = S_SHIFT;
          shift_cnt_d = '0;
          pat_cnt_d   = '0;
          sig_d       = 8'h00;
          pass_d      = 1'b0;
          scan_en_d   = 1'b1;
          busy_d      = 1'b1;
        end
      end
      S_SHIFT: begin
        sig_d = misr_next;
        if (shift_cnt_q == C_SHIFT_LAST) begin
          state_d = S_CAPTURE;
        end else begin
          shift_cnt_d = shift_cnt_q + SW'(1);
          scan_en_d   = 1'b1;
        end
      end
      S_CAPTURE: begin
        pat_cnt_d   = pat_cnt_inc;
        shift_cnt_d = '0;
        scan_en_d   = 1'b1;
        state_d     = (pat_cnt_inc == C_PAT_TOTAL) ? S_UNLOAD : S_SHIFT;
      end
      S_UNLOAD: begin
        sig_d = misr_next;
        if (shift_cnt_q == C_SHIFT_LAST) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          // Compare against the value the MISR takes on this same edge.
          pass_d  = (misr_next == GOLDEN_SIG);
        end else begin
          shift_cnt_d = shift_cnt_q + SW'(1);
          scan_en_d   = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Abort leaves the signature as it was before this cycle's shift.
    if (abort_hit) begin
      state_d     = S_IDLE;
      shift_cnt_d = '0;
      pat_cnt_d   = '0;
      sig_d       = sig_q;
      pass_d      = 1'b0;
      scan_en_d   = 1'b0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      shift_cnt_q <= '0;
      pat_cnt_q   <= '0;
      sig_q       <= 8'h00;
      pass_q      <= 1'b0;
      scan_en_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_cnt_q <= shift_cnt_d;
      pat_cnt_q   <= pat_cnt_d;
      sig_q       <= sig_d;
      pass_q      <= pass_d;
      scan_en_q   <= scan_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign scan_en   = scan_en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign signature = sig_q;

endmodule
`default_nettype wire

// File: tb/tb_bist_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_bist_controller
// Purpose  : Self-checking bench for bist_controller. A default-parameter
//            instance is exercised with random scan responses, restart
//            attempts, mid-run reset, abort (when BIST_ABORT_EN is defined)
//            and back-to-back runs; two CHAIN_LEN=1/NUM_PATTERNS=1 instances
//            cover the minimal chain with both golden values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bist_controller;

  localparam int CL  = 8;
  localparam int NP  = 4;
  localparam int RUN = NP * (CL + 1) + CL + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       scan_out = 1'b0;
  logic       s_start = 1'b0;
  logic       s_scan_out = 1'b0;
`ifdef BIST_ABORT_EN
  logic       abort = 1'b0;
`endif

  logic       scan_en, busy, done, pass;
  logic [7:0] signature;
  logic       s0_scan_en, s0_busy, s0_done, s0_pass;
  logic [7:0] s0_signature;
  logic       s3_scan_en, s3_busy, s3_done, s3_pass;
  logic [7:0] s3_signature;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  bist_controller #(.CHAIN_LEN(CL), .NUM_PATTERNS(NP), .GOLDEN_SIG(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .scan_out(scan_out),
`ifdef BIST_ABORT_EN
    .abort(abort),
`endif
    .scan_en(scan_en), .busy(busy), .done(done), .pass(pass), .signature(signature)
  );

  bist_controller #(.CHAIN_LEN(1), .NUM_PATTERNS(1), .GOLDEN_SIG(8'h00)) dut_s0 (
    .clk(clk), .rst_n(rst_n), .start(s_start), .scan_out(s_scan_out),
`ifdef BIST_ABORT_EN
    .abort(1'b0),
`endif
    .scan_en(s0_scan_en), .busy(s0_busy), .done(s0_done), .pass(s0_pass),
    .signature(s0_signature)
  );

  bist_controller #(.CHAIN_LEN(1), .NUM_PATTERNS(1), .GOLDEN_SIG(8'h03)) dut_s3 (
    .clk(clk), .rst_n(rst_n), .start(s_start), .scan_out(s_scan_out),
`ifdef BIST_ABORT_EN
    .abort(1'b0),
`endif
    .scan_en(s3_scan_en), .busy(s3_busy), .done(s3_done), .pass(s3_pass),
    .signature(s3_signature)
  );

  // Reference MISR step.
  function automatic logic [7:0] misr(input logic [7:0] s, input logic b);
    return {s[6:0], 1'b0} ^ (s[7] ? 8'h1D : 8'h00) ^ {7'b0, b};
  endfunction

  // Expected scan_en in cycle t of a run (cycle 0 = the cycle start is sampled):
  // n patterns of c shift cycles plus one capture, then c unload cycles.
  function automatic bit exp_en(input int t, input int c, input int n);
    int u;
    if (t < 1 || t > n * (c + 1) + c) return 1'b0;
    u = t - 1;
    if (u < n * (c + 1)) return (u % (c + 1)) != c;
    return 1'b1;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    s_start = 1'b1;
    repeat (3) @(negedge clk);
    vecs++;
    if ({scan_en, busy, done, pass} !== 4'b0000)
      $display("FAIL reset_ctrl got %b exp 0000", {scan_en, busy, done, pass});
    vecs++;
    if (signature !== 8'h00) $display("FAIL reset_sig got %h exp 00", signature);
    vecs++;
    if ({s0_scan_en, s0_busy, s0_done, s0_pass, s3_busy, s3_pass} !== 6'b0)
      $display("FAIL reset_small got %b exp 000000",
               {s0_scan_en, s0_busy, s0_done, s0_pass, s3_busy, s3_pass});
    if (signature !== 8'h00 || s0_signature !== 8'h00) errs++;
    if ({scan_en, busy, done, pass} !== 4'b0000) errs++;
    if ({s0_scan_en, s0_busy, s0_done, s0_pass, s3_busy, s3_pass} !== 6'b0) errs++;
    start = 1'b0;
    s_start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One default run. restart_at: cycle to re-pulse start (0 = never).
  // cut_at: cycle in which reset (cut_abort=0) or abort (cut_abort=1) is applied.
  task automatic test_run(input int restart_at, input bit rand_scan,
                          input int cut_at, input bit cut_abort);
    logic [7:0] sig_m;
    logic       b;
    sig_m = 8'h00;
    @(negedge clk);
    start = 1'b1;
    scan_out = 1'b0;
    for (int t = 1; t <= RUN + 3; t++) begin
      @(negedge clk);
      start = (t == restart_at);
      if (cut_at != 0 && t == cut_at + 1) begin
        vecs++;
        if ({busy, scan_en, done, pass} !== 4'b0000) begin
          errs++;
          $display("FAIL cut_ctrl t=%0d got %b exp 0000", t, {busy, scan_en, done, pass});
        end
        vecs++;
        if (signature !== (cut_abort ? sig_m : 8'h00)) begin
          errs++;
          $display("FAIL cut_sig got %h exp %h", signature, cut_abort ? sig_m : 8'h00);
        end
        rst_n = 1'b1;
`ifdef BIST_ABORT_EN
        abort = 1'b0;
`endif
        scan_out = 1'b0;
        for (int k = 0; k < RUN; k++) begin
          @(negedge clk);
          vecs++;
          if (done !== 1'b0 || busy !== 1'b0) begin
            errs++;
            $display("FAIL cut_quiet k=%0d got done=%b busy=%b exp 0 0", k, done, busy);
          end
        end
        return;
      end
      vecs++;
      if (scan_en !== exp_en(t, CL, NP)) begin
        errs++;
        $display("FAIL scan_en t=%0d got %b exp %b", t, scan_en, exp_en(t, CL, NP));
      end
      vecs++;
      if (busy !== (t <= RUN)) begin
        errs++;
        $display("FAIL busy t=%0d got %b exp %b", t, busy, t <= RUN);
      end
      vecs++;
      if (done !== (t == RUN)) begin
        errs++;
        $display("FAIL done t=%0d got %b exp %b", t, done, t == RUN);
      end
      vecs++;
      if (signature !== sig_m) begin
        errs++;
        $display("FAIL signature t=%0d got %h exp %h", t, signature, sig_m);
      end
      if (t >= RUN) begin
        vecs++;
        if (pass !== (sig_m == 8'h00)) begin
          errs++;
          $display("FAIL pass t=%0d got %b exp %b", t, pass, sig_m == 8'h00);
        end
      end
      b = rand_scan ? 1'($urandom % 2) : 1'b0;
      scan_out = b;
      if (exp_en(t, CL, NP) && t != cut_at) sig_m = misr(sig_m, b);
      if (t == cut_at) begin
`ifdef BIST_ABORT_EN
        if (cut_abort) abort = 1'b1;
        else rst_n = 1'b0;
`else
        rst_n = 1'b0;
`endif
      end
    end
  endtask

  task automatic test_back_to_back();
    int first_d, second_d, n_done, waited;
    first_d = -1; second_d = -1; n_done = 0;
    scan_out = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (int t = 1; t <= 100; t++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        n_done++;
        if (first_d < 0) first_d = t;
        else if (second_d < 0) second_d = t;
        vecs++;
        if (pass !== 1'b1) begin
          errs++;
          $display("FAIL b2b_pass t=%0d got %b exp 1", t, pass);
        end
      end
    end
    start = 1'b0;
    vecs++;
    if (first_d != RUN || second_d != 2 * RUN + 1 || n_done != 2) begin
      errs++;
      $display("FAIL b2b_done got first=%0d second=%0d count=%0d exp %0d %0d 2",
               first_d, second_d, n_done, RUN, 2 * RUN + 1);
    end
    waited = 0;
    while (busy !== 1'b0 && waited < RUN + 5) begin
      @(negedge clk);
      waited++;
    end
    vecs++;
    if (busy !== 1'b0) begin
      errs++;
      $display("FAIL b2b_idle got busy=%b exp 0", busy);
    end
  endtask

  task automatic test_min_chain();
    logic [7:0] sig_m;
    sig_m = 8'h00;
    @(negedge clk);
    s_start = 1'b1;
    s_scan_out = 1'b1;
    for (int t = 1; t <= 6; t++) begin
      @(negedge clk);
      s_start = 1'b0;
      vecs++;
      if (s0_scan_en !== exp_en(t, 1, 1) || s3_scan_en !== exp_en(t, 1, 1)) begin
        errs++;
        $display("FAIL min_scan_en t=%0d got %b/%b exp %b", t, s0_scan_en, s3_scan_en,
                 exp_en(t, 1, 1));
      end
      vecs++;
      if (s0_signature !== sig_m || s3_signature !== sig_m) begin
        errs++;
        $display("FAIL min_sig t=%0d got %h/%h exp %h", t, s0_signature, s3_signature, sig_m);
      end
      vecs++;
      if (s0_done !== (t == 4) || s3_done !== (t == 4)) begin
        errs++;
        $display("FAIL min_done t=%0d got %b/%b exp %b", t, s0_done, s3_done, t == 4);
      end
      if (t >= 4) begin
        vecs++;
        if (s0_pass !== (sig_m == 8'h00) || s3_pass !== (sig_m == 8'h03)) begin
          errs++;
          $display("FAIL min_pass t=%0d got %b/%b exp %b/%b", t, s0_pass, s3_pass,
                   sig_m == 8'h00, sig_m == 8'h03);
        end
      end
      if (exp_en(t, 1, 1)) sig_m = misr(sig_m, 1'b1);
    end
    vecs++;
    if (s0_signature !== 8'h03) begin
      errs++;
      $display("FAIL min_final got %h exp 03", s0_signature);
    end
    s_scan_out = 1'b0;
  endtask

  initial begin
    test_reset();
    test_run(0, 1'b0, 0, 1'b0);   // all-zero response: signature 00, pass
    test_run(0, 1'b1, 0, 1'b0);   // random responses
    test_run(10, 1'b1, 0, 1'b0);  // start re-asserted mid-run is ignored
    test_run(0, 1'b1, 40, 1'b0);  // reset during UNLOAD
`ifdef BIST_ABORT_EN
    test_run(0, 1'b1, 3 * (CL + 1), 1'b1);  // abort in the 3rd CAPTURE
    test_run(0, 1'b1, 0, 1'b0);
`endif
    test_back_to_back();
    test_min_chain();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
`default_nettype wire
